bcd_serial_adder_ctrl: RTL and testbench

- Sequences a single 4-bit BCD digit adder across a multi-digit operand pair, one digit per clock, least-significant digit first.
- Sits between a requester issuing a start pulse and the shared digit-add datapath.
- Returns a packed BCD sum, a decimal carry-out and an input-validity flag.
- Trades latency (DIGITS cycles) for area: one digit-adder instance regardless of width.

---
 rtl/bcd_serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder_ctrl.sv
// rtl/bcd_serial_adder_ctrl.sv - serial BCD adder sequencer, one digit per clock, LSD first
// Optional BCD_SUB_EN adds a sub port for ten's-complement subtraction.
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  carry_in,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  bad_digit
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t              state, state_next;
  logic [4*DIGITS-1:0] a_q, b_q;
  logic [IW-1:0]       index;
  logic                carry;
  logic                sub_q;

  logic [3:0]          a_dig, b_raw, b_dig, dig;
  logic [4:0]          s;
  logic                dig_carry, last, dig_bad, sub_now;

`ifdef BCD_SUB_EN
  assign sub_now = sub;
`else
  assign sub_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);
  assign last = (index == IW'(DIGITS - 1));

  // Operands are shifted right each digit, so the current digit is always the low nibble.
  always_comb begin
    a_dig     = a_q[3:0];
    b_raw     = b_q[3:0];
    b_dig     = sub_q ? (4'd9 - b_raw) : b_raw;
    s         = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry};
    dig       = s[3:0];
    dig_carry = 1'b0;
    if (s > 5'd9) begin
      dig       = s[3:0] + 4'd6;
      dig_carry = 1'b1;
    end
    dig_bad   = (a_dig > 4'd9) || (b_raw > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      index     <= '0;
      carry     <= 1'b0;
      sub_q     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            sub_q     <= sub_now;
            // Subtraction completes the ten's complement by injecting +1 at digit 0.
            carry     <= sub_now ? 1'b1 : carry_in;
            index     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            bad_digit <= 1'b0;
          end
        end
        ADD: begin
          a_q       <= a_q >> 4;
          b_q       <= b_q >> 4;
          carry     <= dig_carry;
          index     <= index + 1'b1;
          bad_digit <= bad_digit | dig_bad;
          for (int i = 0; i < DIGITS; i++) begin
            if (index == IW'(i)) sum[4*i +: 4] <= dig;
          end
          if (last) carry_out <= dig_carry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb/tb_bcd_serial_adder_ctrl.sv - directed self-checking bench for bcd_serial_adder_ctrl
module tb_bcd_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
`ifdef BCD_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        bad_digit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef BCD_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .bad_digit (bad_digit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge (end of cycle T).
  task automatic launch(input logic [15:0] ta, input logic [15:0] tbv, input logic tc);
    a        = ta;
    b        = tbv;
    carry_in = tc;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    carry_in = 1'b0;
  endtask

  // Entered in cycle T+1; leaves in cycle T+6 (back in IDLE).
  task automatic expect_result(input string tag, input logic [15:0] es, input logic ec, input logic eb);
    for (int k = 0; k < 4; k++) begin
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " done_early"}, done, 1'b0);
      if (k == 0) chk({tag, " sum_cleared"}, sum, 16'h0000);
      if (k == 2) chk({tag, " sum_partial"}, sum, es & 16'h00FF);
      @(negedge clk);
    end
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    chk({tag, " sum"}, sum, es);
    chk({tag, " carry_out"}, carry_out, ec);
    chk({tag, " bad_digit"}, bad_digit, eb);
    @(negedge clk);
    chk({tag, " done_after"}, done, 1'b0);
    chk({tag, " sum_held"}, sum, es);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    a        = 16'h0;
    b        = 16'h0;
    carry_in = 1'b0;
`ifdef BCD_SUB_EN
    sub      = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst sum", sum, 16'h0);
    chk("rst carry_out", carry_out, 1'b0);
    chk("rst bad_digit", bad_digit, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    launch(16'h1234, 16'h5678, 1'b0);
    expect_result("add1234", 16'h6912, 1'b0, 1'b0);

    launch(16'h9999, 16'h0001, 1'b0);
    expect_result("ripple", 16'h0000, 1'b1, 1'b0);

    launch(16'h0000, 16'h0000, 1'b1);
    expect_result("cin", 16'h0001, 1'b0, 1'b0);

    launch(16'h12A4, 16'h0000, 1'b0);
    expect_result("baddig", 16'h1304, 1'b0, 1'b1);

    launch(16'h1234, 16'h5678, 1'b0);
    chk("ign busy_t1", busy, 1'b1);
    @(negedge clk);
    a     = 16'h9999;
    b     = 16'h9999;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("ign busy", busy, 1'b1);
      chk("ign done_early", done, 1'b0);
      @(negedge clk);
    end
    chk("ign done", done, 1'b1);
    chk("ign sum", sum, 16'h6912);
    chk("ign carry_out", carry_out, 1'b0);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("ign idle_done", done, 1'b0);
      chk("ign idle_busy", busy, 1'b0);
      chk("ign idle_sum", sum, 16'h6912);
      @(negedge clk);
    end
    launch(16'h9999, 16'h9999, 1'b0);
    expect_result("after_ign", 16'h9998, 1'b1, 1'b0);

    launch(16'h9999, 16'h0001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst sum", sum, 16'h0);
    chk("midrst carry_out", carry_out, 1'b0);
    chk("midrst bad_digit", bad_digit, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("midrst no_done", done, 1'b0);
      @(negedge clk);
    end
    launch(16'h0500, 16'h0123, 1'b0);
    expect_result("post_rst", 16'h0623, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
    sub = 1'b1;
    launch(16'h0500, 16'h0123, 1'b0);
    sub = 1'b0;
    expect_result("sub_pos", 16'h0377, 1'b1, 1'b0);
    sub = 1'b1;
    launch(16'h0123, 16'h0500, 1'b1);
    sub = 1'b0;
    expect_result("sub_neg", 16'h9623, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
